evm_ballot_controller: RTL and testbench

Sequencing controller between the raw candidate buttons and the per-candidate vote counters of the two-digit EVM. The presiding officer arms one ballot at a time; the controller accepts exactly one debounced single-button press per armed ballot. It then issues a one-cycle vote strobe to the counter datapath, drives a confirmation beep, and tracks the total ballots cast against a two-digit display limit. Poll close and capacity lockout are handled here, so the counter block only ever sees clean, mutually exclusive one-cycle increments.

---
 rtl/evm_ballot_controller_if.sv | 36 +++
 rtl/evm_ballot_controller.sv | 140 ++++++++++++++
 tb/tb_evm_ballot_controller.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/evm_ballot_controller_if.sv
// Signal bundle between the officer/voter panel and the ballot controller.
// The slave side is the controller; the master side drives buttons and officer requests.
interface evm_ballot_controller_if;
    logic       P1;
    logic       P2;
    logic       P3;
    logic       NOTA;
    logic       BALLOT_EN;
    logic       CLOSE_POLL;
    logic       VOTE_P1;
    logic       VOTE_P2;
    logic       VOTE_P3;
    logic       VOTE_NOTA;
    logic       READY;
    logic       BEEP;
    logic       MULTI;
    logic       FULL;
    logic       CLOSED;
    logic [6:0] TOTAL;
    logic [2:0] state_dbg;

    // Buttons and officer requests are levels sampled on every rising edge. Each
    // VOTE_* strobe is a one-cycle pulse with no back-pressure; the counters must
    // accept it in the cycle it is high.
    modport master (
        output P1, P2, P3, NOTA, BALLOT_EN, CLOSE_POLL,
        input  VOTE_P1, VOTE_P2, VOTE_P3, VOTE_NOTA,
        input  READY, BEEP, MULTI, FULL, CLOSED, TOTAL, state_dbg
    );

    modport slave (
        input  P1, P2, P3, NOTA, BALLOT_EN, CLOSE_POLL,
        output VOTE_P1, VOTE_P2, VOTE_P3, VOTE_NOTA,
        output READY, BEEP, MULTI, FULL, CLOSED, TOTAL, state_dbg
    );
endinterface

// File: rtl/evm_ballot_controller.sv
// Arms one ballot at a time, debounces a single button press, issues one vote strobe,
// beeps, and tracks the ballot total against the display limit and poll close.
module evm_ballot_controller #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int BEEP_CYCLES     = 8,
    parameter int MAX_VOTES       = 99
) (
    input  logic                  CLK,
    input  logic                  CLEAR_N,
    evm_ballot_controller_if.slave bus
);
    typedef enum logic [2:0] {
        S_IDLE, S_WAIT_REL, S_ARMED, S_DEBOUNCE, S_BEEP, S_CLOSED
    } state_t;

    localparam logic [3:0] DEB_N  = 4'(DEBOUNCE_CYCLES);
    localparam logic [7:0] BEEP_N = 8'(BEEP_CYCLES);
    localparam logic [6:0] MAX_V  = 7'(MAX_VOTES);

    state_t     state, state_d;
    logic [3:0] cand, cand_d;
    logic [3:0] cnt, cnt_d;
    logic [7:0] bcnt, bcnt_d;
    logic       close_pend, close_pend_d;
    logic [6:0] total, total_d;
    logic [3:0] vote_d, vote_q;
    logic       beep_d, beep_q;
    logic       ready_q, closed_q, full_q;

    logic [3:0] btn;
    logic       btn_one, btn_many, at_full;

    assign btn      = {bus.NOTA, bus.P3, bus.P2, bus.P1};
    assign btn_one  = (btn != 4'd0) && ((btn & (btn - 4'd1)) == 4'd0);
    assign btn_many = (btn != 4'd0) && !btn_one;
    assign at_full  = (total == MAX_V);

    always_comb begin
        state_d      = state;
        cand_d       = cand;
        cnt_d        = cnt;
        bcnt_d       = bcnt;
        close_pend_d = close_pend;
        total_d      = total;
        vote_d       = 4'd0;
        beep_d       = 1'b0;
        case (state)
            S_IDLE: begin
                if (bus.CLOSE_POLL)                  state_d = S_CLOSED;
                else if (bus.BALLOT_EN && !at_full)  state_d = S_WAIT_REL;
            end
            S_WAIT_REL: begin
                if (bus.CLOSE_POLL)     state_d = S_CLOSED;
                else if (btn == 4'd0)   state_d = S_ARMED;
            end
            S_ARMED: begin
                if (bus.CLOSE_POLL) begin
                    state_d = S_CLOSED;
                end else if (btn_one) begin
                    cand_d  = btn;
                    cnt_d   = 4'd1;
                    state_d = S_DEBOUNCE;
                end
            end
            S_DEBOUNCE: begin
                // A completing sample beats a simultaneous close: the vote is cast first.
                if (btn == cand && cnt + 4'd1 == DEB_N) begin
                    vote_d       = cand;
                    total_d      = total + 7'd1;
                    bcnt_d       = 8'd0;
                    close_pend_d = 1'b0;
                    state_d      = bus.CLOSE_POLL ? S_CLOSED : S_BEEP;
                end else if (bus.CLOSE_POLL) begin
                    state_d = S_CLOSED;
                end else if (btn == cand) begin
                    cnt_d = cnt + 4'd1;
                end else begin
                    state_d = S_ARMED;
                end
            end
            S_BEEP: begin
                // The strobe cycle is bcnt==0 with BEEP still low; BEEP covers the next BEEP_N cycles.
                if (bcnt == BEEP_N) begin
                    state_d      = (close_pend || bus.CLOSE_POLL) ? S_CLOSED : S_IDLE;
                    close_pend_d = 1'b0;
                end else begin
                    bcnt_d = bcnt + 8'd1;
                    beep_d = 1'b1;
                    if (bus.CLOSE_POLL) close_pend_d = 1'b1;
                end
            end
            S_CLOSED: begin
                state_d = S_CLOSED;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!CLEAR_N) begin
            state      <= S_IDLE;
            cand       <= 4'd0;
            cnt        <= 4'd0;
            bcnt       <= 8'd0;
            close_pend <= 1'b0;
            total      <= 7'd0;
            vote_q     <= 4'd0;
            beep_q     <= 1'b0;
            ready_q    <= 1'b0;
            closed_q   <= 1'b0;
            full_q     <= 1'b0;
        end else begin
            state      <= state_d;
            cand       <= cand_d;
            cnt        <= cnt_d;
            bcnt       <= bcnt_d;
            close_pend <= close_pend_d;
            total      <= total_d;
            vote_q     <= vote_d;
            beep_q     <= beep_d;
            ready_q    <= (state_d == S_ARMED) || (state_d == S_DEBOUNCE);
            closed_q   <= (state_d == S_CLOSED);
            full_q     <= (total_d == MAX_V);
        end
    end

    assign bus.VOTE_P1   = vote_q[0];
    assign bus.VOTE_P2   = vote_q[1];
    assign bus.VOTE_P3   = vote_q[2];
    assign bus.VOTE_NOTA = vote_q[3];
    assign bus.READY     = ready_q;
    assign bus.BEEP      = beep_q;
    assign bus.MULTI     = (state == S_ARMED) && btn_many;
    assign bus.FULL      = full_q;
    assign bus.CLOSED    = closed_q;
    assign bus.TOTAL     = total;
    assign bus.state_dbg = state;
endmodule

// File: tb/tb_evm_ballot_controller.sv
// Bench for evm_ballot_controller: two instances (default limit and a 3-ballot limit)
// driven by the same directed and random stimulus and compared against a ballot model.
module tb_evm_ballot_controller;
  localparam int D     = 4;
  localparam int B_A   = 8;
  localparam int MAX_A = 99;
  localparam int B_B   = 3;
  localparam int MAX_B = 3;

  localparam int PH_IDLE   = 0;
  localparam int PH_WREL   = 1;
  localparam int PH_ARMED  = 2;
  localparam int PH_DEB    = 3;
  localparam int PH_BEEP   = 4;
  localparam int PH_CLOSED = 5;

  // clock / reset
  logic CLK = 1'b0;
  logic CLEAR_N = 1'b0;
  always #5 CLK = ~CLK;

  evm_ballot_controller_if bus_a();
  evm_ballot_controller_if bus_b();

  evm_ballot_controller #(.DEBOUNCE_CYCLES(D), .BEEP_CYCLES(B_A), .MAX_VOTES(MAX_A)) dut_a (
    .CLK(CLK), .CLEAR_N(CLEAR_N), .bus(bus_a)
  );
  evm_ballot_controller #(.DEBOUNCE_CYCLES(D), .BEEP_CYCLES(B_B), .MAX_VOTES(MAX_B)) dut_b (
    .CLK(CLK), .CLEAR_N(CLEAR_N), .bus(bus_b)
  );

  logic [3:0] vote_o[2];
  logic [6:0] total_o[2];
  logic       ready_o[2], beep_o[2], multi_o[2], full_o[2], closed_o[2];

  assign vote_o[0]   = {bus_a.VOTE_NOTA, bus_a.VOTE_P3, bus_a.VOTE_P2, bus_a.VOTE_P1};
  assign vote_o[1]   = {bus_b.VOTE_NOTA, bus_b.VOTE_P3, bus_b.VOTE_P2, bus_b.VOTE_P1};
  assign total_o[0]  = bus_a.TOTAL;
  assign total_o[1]  = bus_b.TOTAL;
  assign ready_o[0]  = bus_a.READY;
  assign ready_o[1]  = bus_b.READY;
  assign beep_o[0]   = bus_a.BEEP;
  assign beep_o[1]   = bus_b.BEEP;
  assign multi_o[0]  = bus_a.MULTI;
  assign multi_o[1]  = bus_b.MULTI;
  assign full_o[0]   = bus_a.FULL;
  assign full_o[1]   = bus_b.FULL;
  assign closed_o[0] = bus_a.CLOSED;
  assign closed_o[1] = bus_b.CLOSED;

  // reference model, one slot per instance
  int         m_phase[2], m_run[2], m_beep_left[2], m_total[2];
  int         m_beep_len[2], m_max[2];
  logic [3:0] m_cand[2], m_vote[2];
  bit         m_pend[2], m_beep[2];

  // scoreboard: {instance, one-hot candidate}
  logic [4:0] exp_q[$];

  int n_checks = 0;
  int n_errors = 0;
  int closed_run = 0;
  int full_run = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_step(input int i, input logic [3:0] btn, input logic en,
                            input logic cls, input logic clr_n);
    m_vote[i] = 4'd0;
    m_beep[i] = 1'b0;
    if (!clr_n) begin
      m_phase[i] = PH_IDLE;
      m_total[i] = 0;
      m_pend[i] = 1'b0;
      m_run[i] = 0;
      m_beep_left[i] = 0;
      m_cand[i] = 4'd0;
      return;
    end
    case (m_phase[i])
      PH_IDLE: begin
        if (cls) m_phase[i] = PH_CLOSED;
        else if (en && m_total[i] < m_max[i]) m_phase[i] = PH_WREL;
      end
      PH_WREL: begin
        if (cls) m_phase[i] = PH_CLOSED;
        else if (btn == 4'd0) m_phase[i] = PH_ARMED;
      end
      PH_ARMED: begin
        if (cls) m_phase[i] = PH_CLOSED;
        else if ($countones(btn) == 1) begin
          m_cand[i] = btn;
          m_run[i] = 1;
          m_phase[i] = PH_DEB;
        end
      end
      PH_DEB: begin
        if (btn == m_cand[i] && m_run[i] + 1 == D) begin
          m_vote[i] = m_cand[i];
          m_total[i]++;
          m_beep_left[i] = m_beep_len[i];
          m_pend[i] = 1'b0;
          m_phase[i] = cls ? PH_CLOSED : PH_BEEP;
        end else if (cls) m_phase[i] = PH_CLOSED;
        else if (btn == m_cand[i]) m_run[i]++;
        else m_phase[i] = PH_ARMED;
      end
      PH_BEEP: begin
        if (cls) m_pend[i] = 1'b1;
        if (m_beep_left[i] > 0) begin
          m_beep_left[i]--;
          m_beep[i] = 1'b1;
        end else begin
          m_phase[i] = m_pend[i] ? PH_CLOSED : PH_IDLE;
          m_pend[i] = 1'b0;
        end
      end
      default: ;
    endcase
  endtask

  task automatic check_outputs(input int i);
    logic [4:0] ent;
    check($sformatf("vote%0d", i), vote_o[i], m_vote[i]);
    check($sformatf("ready%0d", i), ready_o[i], (m_phase[i] == PH_ARMED || m_phase[i] == PH_DEB));
    check($sformatf("beep%0d", i), beep_o[i], m_beep[i]);
    check($sformatf("closed%0d", i), closed_o[i], (m_phase[i] == PH_CLOSED));
    check($sformatf("full%0d", i), full_o[i], (m_total[i] == m_max[i]));
    check($sformatf("total%0d", i), total_o[i], m_total[i]);
    if (m_vote[i] != 4'd0) exp_q.push_back({i[0], m_vote[i]});
    if (vote_o[i] != 4'd0) begin
      if (exp_q.size() > 0) begin
        ent = exp_q.pop_front();
        check($sformatf("sb_vote%0d", i), {i[0], vote_o[i]}, ent);
      end else begin
        check($sformatf("sb_spurious%0d", i), vote_o[i], 4'd0);
      end
    end
  endtask

  // driver: one clock cycle of stimulus applied to both instances
  task automatic tick(input logic [3:0] btn, input logic en, input logic cls, input logic clr_n);
    bus_a.P1 = btn[0]; bus_a.P2 = btn[1]; bus_a.P3 = btn[2]; bus_a.NOTA = btn[3];
    bus_b.P1 = btn[0]; bus_b.P2 = btn[1]; bus_b.P3 = btn[2]; bus_b.NOTA = btn[3];
    bus_a.BALLOT_EN = en;  bus_b.BALLOT_EN = en;
    bus_a.CLOSE_POLL = cls; bus_b.CLOSE_POLL = cls;
    CLEAR_N = clr_n;
    #1;
    for (int i = 0; i < 2; i++)
      check($sformatf("multi%0d", i), multi_o[i], (m_phase[i] == PH_ARMED) && ($countones(btn) > 1));
    @(posedge CLK);
    for (int i = 0; i < 2; i++) model_step(i, btn, en, cls, clr_n);
    #1;
    for (int i = 0; i < 2; i++) check_outputs(i);
  endtask

  task automatic hold(input logic [3:0] btn, input int n);
    for (int k = 0; k < n; k++) tick(btn, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic arm();
    tick(4'd0, 1'b1, 1'b0, 1'b1);
    tick(4'd0, 1'b0, 1'b0, 1'b1);
  endtask

  initial begin
    logic [3:0] held;
    logic       en, cls, clr_n;
    m_beep_len[0] = B_A; m_max[0] = MAX_A;
    m_beep_len[1] = B_B; m_max[1] = MAX_B;
    for (int i = 0; i < 2; i++) begin
      m_phase[i] = PH_IDLE; m_total[i] = 0; m_run[i] = 0; m_beep_left[i] = 0;
      m_cand[i] = 4'd0; m_vote[i] = 4'd0; m_pend[i] = 1'b0; m_beep[i] = 1'b0;
    end

    // reset
    tick(4'd0, 1'b0, 1'b0, 1'b0);
    tick(4'd0, 1'b1, 1'b1, 1'b0);
    check("rst_total", total_o[0], 7'd0);

    // one clean P2 vote
    arm();
    hold(4'b0010, 6);
    hold(4'd0, 12);
    check("p2_total", total_o[0], 7'd1);

    // P1 held through arming cannot cast; P3 after release does
    tick(4'b0001, 1'b1, 1'b0, 1'b1);
    hold(4'b0001, 3);
    hold(4'd0, 1);
    hold(4'b0100, 5);
    hold(4'd0, 12);
    check("p3_total", total_o[0], 7'd2);

    // P1+NOTA together, then NOTA dropped
    arm();
    hold(4'b1001, 10);
    hold(4'b0001, 5);
    hold(4'd0, 12);
    check("full_b_after3", full_o[1], 1'b1);

    // P3 glitch: instance b is full and must not arm
    arm();
    hold(4'b0100, 2);
    hold(4'd0, 3);
    check("glitch_total", total_o[0], 7'd3);

    // close in the completion cycle, then BALLOT_EN ignored, then clear
    hold(4'b0001, 3);
    tick(4'b0001, 1'b0, 1'b1, 1'b1);
    for (int k = 0; k < 5; k++) tick(4'd0, 1'b1, 1'b0, 1'b1);
    check("closed_a", closed_o[0], 1'b1);
    tick(4'd0, 1'b0, 1'b0, 1'b0);
    hold(4'd0, 2);

    // fill the 3-ballot instance, then clear mid-debounce
    for (int v = 0; v < 3; v++) begin
      arm();
      hold(4'b0001 << v, 5);
      hold(4'd0, 10);
    end
    arm();
    hold(4'b0010, 2);
    tick(4'b0010, 1'b0, 1'b0, 1'b0);
    hold(4'b0010, 3);
    check("clr_mid_total", total_o[0], 7'd0);

    // random traffic
    held = 4'd0;
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 5) == 0) begin
        case ($urandom_range(0, 9))
          0, 1, 2, 3: held = 4'd0;
          9:          held = 4'($urandom_range(1, 15));
          default:    held = 4'(1 << $urandom_range(0, 3));
        endcase
      end
      en = ($urandom_range(0, 3) == 0);
      cls = ($urandom_range(0, 249) == 0);
      closed_run = (m_phase[0] == PH_CLOSED || m_phase[1] == PH_CLOSED) ? closed_run + 1 : 0;
      full_run = (m_total[1] == MAX_B) ? full_run + 1 : 0;
      clr_n = !($urandom_range(0, 499) == 0 || closed_run > 30 || full_run > 200);
      tick(held, en, cls, clr_n);
    end
    hold(4'd0, 12);

    check("sb_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
